// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Processor-side data-access bus between a requester and data_mem_responder.
//   Signals:
//     req   : access request, held high by the requester until ack is seen
//     we    : 1 = store, 0 = load (sampled with req)
//     addr  : 16-bit byte address
//     wdata : store data (sampled with req)
//     rdata : registered load result
//     ack   : one-cycle completion pulse
//     busy  : request accepted, not yet acknowledged
//     err   : one-cycle fault flag, coincident with ack
//   Modports: master (requester side), slave (responder side).
interface data_mem_responder_if #(
    parameter int BITS = 16
);
    logic            req;
    logic            we;
    logic [15:0]     addr;
    logic [BITS-1:0] wdata;
    logic [BITS-1:0] rdata;
    logic            ack;
    logic            busy;
    logic            err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-outstanding data-memory responder with a programmable number of
//   wait states. A request is latched in IDLE, waits WAIT+1 edges in WAITING,
//   performs the access on the last of those edges and acknowledges for one
//   cycle in RESP.
//   Parameters:
//     BITS       : data word width
//     DEPTH_LOG2 : log2 of storage depth in words
//     WAIT       : wait-state count, 0..15
//   Ports:
//     clk : clock, all state on the rising edge
//     rst : synchronous active-high reset (storage contents are kept)
//     bus : data_mem_responder_if.slave (req/we/addr/wdata in,
//           rdata/ack/busy/err out)
//   Optional feature (macro MISALIGN_CHECK_EN):
//     defined   : addr[0]=1 on an accepted request completes with ack=1 and
//                 err=1 at normal latency; no store, rdata unchanged
//     undefined : addr[0] is ignored and err is tied low
module data_mem_responder #(
    parameter int BITS       = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITING,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [BITS-1:0]       r_wdata;
    logic [BITS-1:0]       r_rdata;
    logic [BITS-1:0]       r_mem [DEPTH];
    logic                  w_accept;
    logic                  w_access;
    logic                  w_fault;

`ifdef MISALIGN_CHECK_EN
    logic                  r_misalign;
    assign w_fault = r_misalign;
`else
    assign w_fault = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.req;
    assign w_access = (r_state == S_WAITING) && (r_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        bus.ack  = 1'b0;
        bus.busy = 1'b0;
        bus.err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_next = S_WAITING;
                end
            end
            S_WAITING: begin
                bus.busy = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.ack = 1'b1;
                bus.err = w_fault;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request fields are captured only at acceptance so later changes on the
    // bus cannot disturb the transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= WAIT_LD;
                r_we    <= bus.we;
                r_idx   <= bus.addr[DEPTH_LOG2:1];
                r_wdata <= bus.wdata;
`ifdef MISALIGN_CHECK_EN
                r_misalign <= bus.addr[0];
`endif
            end else if ((r_state == S_WAITING) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !r_we && !w_fault) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Storage has no reset; the rst gate aborts a store whose access edge
    // coincides with reset.
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_we && !w_fault) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed and randomized checks of data_mem_responder against a word-array
//   reference model. dut0 runs with WAIT=2, dut1 with WAIT=0 for the
//   held-request back-to-back stream.
module tb_data_mem_responder;
    localparam int BITS  = 16;
    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;
    localparam int W0    = 2;
    localparam int W1    = 0;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if #(.BITS(BITS)) if0 ();
    data_mem_responder_if #(.BITS(BITS)) if1 ();

    data_mem_responder #(.BITS(BITS), .DEPTH_LOG2(DL), .WAIT(W0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    data_mem_responder #(.BITS(BITS), .DEPTH_LOG2(DL), .WAIT(W1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] mem0 [DEPTH];
    logic [15:0] mem1 [DEPTH];
    logic [15:0] exp_rd0;
    logic [15:0] exp_rd1;

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on dut0; starts and ends #1 after an edge with dut0 idle.
    task automatic access0(input logic w, input logic [15:0] a, input logic [15:0] d,
                           input bit scramble, input string tag);
        int cyc;
        int busy_n;
        bit bad;
        bad = MIS && a[0];
        if0.req = 1'b1; if0.we = w; if0.addr = a; if0.wdata = d;
        @(posedge clk); #1;
        if (scramble) begin
            if0.addr  = 16'($urandom);
            if0.wdata = 16'($urandom);
            if0.we    = ~w;
        end
        cyc = 0; busy_n = 0;
        while (if0.ack !== 1'b1 && cyc < 40) begin
            if (if0.busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
        if (!bad) begin
            if (w) mem0[widx(a)] = d;
            else   exp_rd0 = mem0[widx(a)];
        end
        check({tag, "/latency"}, 32'(cyc), 32'(W0 + 1));
        check({tag, "/busy_cycles"}, 32'(busy_n), 32'(W0 + 1));
        check({tag, "/err"}, {31'd0, if0.err}, {31'd0, bad});
        check({tag, "/busy_in_ack"}, {31'd0, if0.busy}, 32'd0);
        check({tag, "/rdata"}, {16'd0, if0.rdata}, {16'd0, exp_rd0});
        if0.req = 1'b0;
        @(posedge clk); #1;
        check({tag, "/ack_pulse"}, {31'd0, if0.ack}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s_addr [8];
        logic        s_we   [8];
        logic [15:0] s_d    [8];
        logic [15:0] prior;
        int          op;
        int          k;

        rst = 1'b1;
        if0.req = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.wdata = '0;
        if1.req = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        check("reset/ack",   {31'd0, if0.ack},  32'd0);
        check("reset/busy",  {31'd0, if0.busy}, 32'd0);
        check("reset/err",   {31'd0, if0.err},  32'd0);
        check("reset/rdata", {16'd0, if0.rdata}, 32'd0);
        check("reset/rdata1", {16'd0, if1.rdata}, 32'd0);

        // Idle with req low: nothing moves.
        repeat (3) @(posedge clk);
        #1;
        check("idle/busy", {31'd0, if0.busy}, 32'd0);
        check("idle/ack",  {31'd0, if0.ack},  32'd0);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            access0(1'b1, 16'(i * 2), 16'($urandom), 1'b0, "fill");
        end

        access0(1'b1, 16'h0010, 16'hBEEF, 1'b0, "beef_st");
        access0(1'b0, 16'h0010, 16'h0000, 1'b0, "beef_ld");
        check("beef/value", {16'd0, if0.rdata}, 32'h0000BEEF);

        access0(1'b1, 16'h0202, 16'h1234, 1'b0, "alias_st");
        access0(1'b0, 16'h0002, 16'h0000, 1'b0, "alias_ld");
        check("alias/value", {16'd0, if0.rdata}, 32'h00001234);

        prior = mem0[widx(16'h0030)];
        access0(1'b1, 16'h0031, 16'hAAAA, 1'b0, "mis_st");
        access0(1'b0, 16'h0030, 16'h0000, 1'b0, "mis_ld");
        check("mis/word30", {16'd0, if0.rdata}, {16'd0, (MIS ? prior : 16'hAAAA)});

        access0(1'b1, 16'h0040, 16'hC0DE, 1'b1, "latch_st");
        access0(1'b0, 16'h0040, 16'h0000, 1'b1, "latch_ld");
        check("latch/value", {16'd0, if0.rdata}, 32'h0000C0DE);

        // Abort a store with reset while it is waiting.
        if0.req = 1'b1; if0.we = 1'b1; if0.addr = 16'h0020; if0.wdata = 16'h5A5A;
        @(posedge clk); #1;
        check("abort/busy_before", {31'd0, if0.busy}, 32'd1);
        if0.req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        check("abort/busy",  {31'd0, if0.busy}, 32'd0);
        check("abort/rdata", {16'd0, if0.rdata}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort/no_ack", {31'd0, if0.ack}, 32'd0);
            @(posedge clk); #1;
        end
        access0(1'b0, 16'h0020, 16'h0000, 1'b0, "abort_ld");

        for (int i = 0; i < 40; i++) begin
            access0(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), "rand");
        end

        // WAIT=0 with req held high: four stores then four aliased loads.
        for (int i = 0; i < 4; i++) begin
            s_addr[i] = 16'(i * 74) + (16'($urandom) & 16'hFE00);
            s_we[i]   = 1'b1;
            s_d[i]    = 16'($urandom);
            s_addr[7 - i] = 16'(i * 74) + (16'($urandom) & 16'hFE00);
            s_we[7 - i]   = 1'b0;
            s_d[7 - i]    = 16'($urandom);
        end
        op = 0; k = 0;
        if1.req = 1'b1; if1.we = s_we[0]; if1.addr = s_addr[0]; if1.wdata = s_d[0];
        while (op < 8 && k < 60) begin
            @(posedge clk); #1;
            k++;
            check("b2b/ack",  {31'd0, if1.ack},  {31'd0, ((k % 3) == 2)});
            check("b2b/busy", {31'd0, if1.busy}, {31'd0, ((k % 3) == 1)});
            if ((k % 3) == 2) begin
                if (s_we[op]) mem1[widx(s_addr[op])] = s_d[op];
                else          exp_rd1 = mem1[widx(s_addr[op])];
                check("b2b/rdata", {16'd0, if1.rdata}, {16'd0, exp_rd1});
                op++;
                if (op < 8) begin
                    if1.we = s_we[op]; if1.addr = s_addr[op]; if1.wdata = s_d[op];
                end else begin
                    if1.req = 1'b0;
                end
            end
        end
        check("b2b/done", 32'(op), 32'd8);
        repeat (2) @(posedge clk);
        #1;
        check("b2b/idle_busy", {31'd0, if1.busy}, 32'd0);
        check("b2b/idle_ack",  {31'd0, if1.ack},  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
